// File: rtl/serial_parity_checker.sv
// Bit-serial frame receiver: deserialises DATA_BITS data bits (LSB first) plus a
// parity bit, checks parity at frame end and keeps a saturating error count.
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 sync,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic              ODD      = (ODD_PARITY != 0);

  typedef enum logic {S_DATA, S_PARITY} state_t;

  state_t                state;
  logic [IDX_W-1:0]      bit_idx;
  logic                  par;
  logic [DATA_BITS-1:0]  shreg;
  logic                  accept_par;
  logic                  frame_err;

  always_comb begin
    accept_par = in_valid && !sync && (state == S_PARITY);
    frame_err  = ((par ^ in_bit) != ODD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DATA;
      bit_idx    <= '0;
      par        <= 1'b0;
      shreg      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sync) begin
        state   <= S_DATA;
        bit_idx <= '0;
        par     <= 1'b0;
      end else if (in_valid) begin
        unique case (state)
          S_DATA: begin
            shreg[bit_idx] <= in_bit;
            par            <= par ^ in_bit;
            if (bit_idx == LAST_IDX) begin
              state   <= S_PARITY;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
          S_PARITY: begin
            out_valid  <= 1'b1;
            out_data   <= shreg;
            parity_err <= frame_err;
            state      <= S_DATA;
            bit_idx    <= '0;
            par        <= 1'b0;
          end
          default: state <= S_DATA;
        endcase
      end

      // err_clr wins over a coincident failing completion, dropping that error
      if (err_clr)
        err_count <= '0;
      else if (accept_par && frame_err && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
